// File: rtl/snowbro2_snd_bus_if.sv
// rtl/snowbro2_snd_bus_if.sv - 68000 sound-window bus and YM2151/OKI6295 port signals
interface snowbro2_snd_bus_if;
    logic       SND_SEL;
    logic [1:0] CPU_A;
    logic       CPU_AS_N;
    logic       CPU_LDS_N;
    logic       CPU_RW;
    logic [7:0] CPU_DIN;
    logic [7:0] CPU_DOUT;
    logic       CPU_DTACK_N;
    logic       YM2151_CS;
    logic       YM2151_WE;
    logic       YM2151_WR_CMD;
    logic [7:0] YM2151_DIN;
    logic [7:0] YM2151_DOUT;
    logic       OKI_CS;
    logic       OKI_WE;
    logic [7:0] OKI_DIN;
    logic [7:0] OKI_DOUT;
    logic       OKI_BANK;

    modport master (
        output SND_SEL, CPU_A, CPU_AS_N, CPU_LDS_N, CPU_RW, CPU_DIN,
        output YM2151_DOUT, OKI_DOUT,
        input  CPU_DOUT, CPU_DTACK_N,
        input  YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN,
        input  OKI_CS, OKI_WE, OKI_DIN, OKI_BANK
    );

    modport slave (
        input  SND_SEL, CPU_A, CPU_AS_N, CPU_LDS_N, CPU_RW, CPU_DIN,
        input  YM2151_DOUT, OKI_DOUT,
        output CPU_DOUT, CPU_DTACK_N,
        output YM2151_CS, YM2151_WE, YM2151_WR_CMD, YM2151_DIN,
        output OKI_CS, OKI_WE, OKI_DIN, OKI_BANK
    );
endinterface

// File: rtl/snowbro2_snd_bus.sv
// rtl/snowbro2_snd_bus.sv - 68000 byte-cycle bridge to YM2151/OKI6295 strobes with OKI bank register
// One access per address strobe: IDLE -> ACCESS (counted strobe) -> ACK (DTACK until AS_N rises).
module snowbro2_snd_bus #(
    parameter int WR_CYCLES = 4,
    parameter int RD_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    snowbro2_snd_bus_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] a_q, a_d;
    logic       rw_q, rw_d;
    logic [7:0] dout_q, dout_d;
    logic       dtack_n_q, dtack_n_d;
    logic       ym_cs_q, ym_cs_d;
    logic       ym_we_q, ym_we_d;
    logic       ym_wr_cmd_q, ym_wr_cmd_d;
    logic [7:0] ym_din_q, ym_din_d;
    logic       oki_cs_q, oki_cs_d;
    logic       oki_we_q, oki_we_d;
    logic [7:0] oki_din_q, oki_din_d;
    logic       oki_bank_q, oki_bank_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        rw_d        = rw_q;
        dout_d      = dout_q;
        dtack_n_d   = dtack_n_q;
        ym_cs_d     = ym_cs_q;
        ym_we_d     = ym_we_q;
        ym_wr_cmd_d = ym_wr_cmd_q;
        ym_din_d    = ym_din_q;
        oki_cs_d    = oki_cs_q;
        oki_we_d    = oki_we_q;
        oki_din_d   = oki_din_q;
        oki_bank_d  = oki_bank_q;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.CPU_AS_N && bus.SND_SEL) begin
                    if (!bus.CPU_LDS_N) begin
                        state_d = S_ACCESS;
                        a_d     = bus.CPU_A;
                        rw_d    = bus.CPU_RW;
                        cnt_d   = bus.CPU_RW ? RD_LOAD : WR_LOAD;
                        unique case (bus.CPU_A)
                            2'd0, 2'd1: begin
                                ym_cs_d     = 1'b1;
                                ym_we_d     = bus.CPU_RW;
                                ym_wr_cmd_d = bus.CPU_A[0];
                                if (!bus.CPU_RW) ym_din_d = bus.CPU_DIN;
                            end
                            2'd2: begin
                                oki_cs_d = 1'b1;
                                oki_we_d = bus.CPU_RW;
                                if (!bus.CPU_RW) oki_din_d = bus.CPU_DIN;
                            end
                            default: begin
                                // Bank register: no chip strobe, just the timed cycle.
                                if (!bus.CPU_RW) oki_bank_d = bus.CPU_DIN[0];
                            end
                        endcase
                    end else begin
                        // Upper-byte-only access: acknowledge so the CPU does not hang.
                        state_d   = S_ACK;
                        dtack_n_d = 1'b0;
                    end
                end
            end

            S_ACCESS: begin
                if (bus.CPU_AS_N) begin
                    state_d  = S_IDLE;
                    ym_cs_d  = 1'b0;
                    ym_we_d  = 1'b1;
                    oki_cs_d = 1'b0;
                    oki_we_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d   = S_ACK;
                    dtack_n_d = 1'b0;
                    ym_cs_d   = 1'b0;
                    ym_we_d   = 1'b1;
                    oki_cs_d  = 1'b0;
                    oki_we_d  = 1'b1;
                    if (rw_q) begin
                        unique case (a_q)
                            2'd0, 2'd1: dout_d = bus.YM2151_DOUT;
                            2'd2:       dout_d = bus.OKI_DOUT;
                            default:    dout_d = {7'b0, oki_bank_q};
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_ACK: begin
                if (bus.CPU_AS_N) begin
                    state_d   = S_IDLE;
                    dtack_n_d = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                dtack_n_d = 1'b1;
                ym_cs_d   = 1'b0;
                ym_we_d   = 1'b1;
                oki_cs_d  = 1'b0;
                oki_we_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            a_q         <= 2'd0;
            rw_q        <= 1'b1;
            dout_q      <= 8'd0;
            dtack_n_q   <= 1'b1;
            ym_cs_q     <= 1'b0;
            ym_we_q     <= 1'b1;
            ym_wr_cmd_q <= 1'b0;
            ym_din_q    <= 8'd0;
            oki_cs_q    <= 1'b0;
            oki_we_q    <= 1'b1;
            oki_din_q   <= 8'd0;
            oki_bank_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            rw_q        <= rw_d;
            dout_q      <= dout_d;
            dtack_n_q   <= dtack_n_d;
            ym_cs_q     <= ym_cs_d;
            ym_we_q     <= ym_we_d;
            ym_wr_cmd_q <= ym_wr_cmd_d;
            ym_din_q    <= ym_din_d;
            oki_cs_q    <= oki_cs_d;
            oki_we_q    <= oki_we_d;
            oki_din_q   <= oki_din_d;
            oki_bank_q  <= oki_bank_d;
        end
    end

    assign bus.CPU_DOUT      = dout_q;
    assign bus.CPU_DTACK_N   = dtack_n_q;
    assign bus.YM2151_CS     = ym_cs_q;
    assign bus.YM2151_WE     = ym_we_q;
    assign bus.YM2151_WR_CMD = ym_wr_cmd_q;
    assign bus.YM2151_DIN    = ym_din_q;
    assign bus.OKI_CS        = oki_cs_q;
    assign bus.OKI_WE        = oki_we_q;
    assign bus.OKI_DIN       = oki_din_q;
    assign bus.OKI_BANK      = oki_bank_q;

endmodule

// File: tb/tb_snowbro2_snd_bus.sv
// tb/tb_snowbro2_snd_bus.sv - directed self-checking bench for snowbro2_snd_bus
module tb_snowbro2_snd_bus;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snowbro2_snd_bus_if bus ();

    snowbro2_snd_bus #(.WR_CYCLES(4), .RD_CYCLES(2)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int n_ycs, n_ywe, n_ocs, n_owe, n_dtk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_dtack_n"}, bus.CPU_DTACK_N, 1'b1);
        chk8({tag, "_dout"}, bus.CPU_DOUT, 8'h00);
        chk1({tag, "_ym_cs"}, bus.YM2151_CS, 1'b0);
        chk1({tag, "_ym_we"}, bus.YM2151_WE, 1'b1);
        chk1({tag, "_ym_wr_cmd"}, bus.YM2151_WR_CMD, 1'b0);
        chk8({tag, "_ym_din"}, bus.YM2151_DIN, 8'h00);
        chk1({tag, "_oki_cs"}, bus.OKI_CS, 1'b0);
        chk1({tag, "_oki_we"}, bus.OKI_WE, 1'b1);
        chk8({tag, "_oki_din"}, bus.OKI_DIN, 8'h00);
        chk1({tag, "_oki_bank"}, bus.OKI_BANK, 1'b0);
    endtask

    // Entered just after a falling edge; SND_SEL and CPU_DIN are disturbed
    // once the cycle has started to prove the latched values are used.
    task automatic cpu_cycle(input logic [1:0] a, input logic rw, input logic [7:0] d,
                             input logic lds_n, input int hold);
        int overlap;
        overlap = 0;
        n_ycs = 0; n_ywe = 0; n_ocs = 0; n_owe = 0; n_dtk = 0;
        bus.SND_SEL   = 1'b1;
        bus.CPU_A     = a;
        bus.CPU_RW    = rw;
        bus.CPU_DIN   = d;
        bus.CPU_LDS_N = lds_n;
        bus.CPU_AS_N  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.SND_SEL = 1'b0;
                bus.CPU_DIN = ~d;
            end
            if (bus.YM2151_CS)    n_ycs++;
            if (!bus.YM2151_WE)   n_ywe++;
            if (bus.OKI_CS)       n_ocs++;
            if (!bus.OKI_WE)      n_owe++;
            if (!bus.CPU_DTACK_N) n_dtk++;
            if (bus.YM2151_CS && bus.OKI_CS) overlap++;
        end
        chki("cs_overlap", overlap, 0);
        bus.CPU_AS_N  = 1'b1;
        bus.CPU_LDS_N = 1'b1;
        @(negedge clk);
        chk1("dtack_release", bus.CPU_DTACK_N, 1'b1);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.SND_SEL     = 1'b0;
        bus.CPU_A       = 2'd0;
        bus.CPU_AS_N    = 1'b1;
        bus.CPU_LDS_N   = 1'b1;
        bus.CPU_RW      = 1'b1;
        bus.CPU_DIN     = 8'h00;
        bus.YM2151_DOUT = 8'h5A;
        bus.OKI_DOUT    = 8'h0F;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // YM register address then data
        cpu_cycle(2'd0, 1'b0, 8'h28, 1'b0, 10);
        chki("ym0_cs", n_ycs, 4);
        chki("ym0_we", n_ywe, 4);
        chki("ym0_oki_cs", n_ocs, 0);
        chki("ym0_oki_we", n_owe, 0);
        chki("ym0_dtack", n_dtk, 6);
        chk8("ym0_din", bus.YM2151_DIN, 8'h28);
        chk1("ym0_wr_cmd", bus.YM2151_WR_CMD, 1'b0);

        cpu_cycle(2'd1, 1'b0, 8'h7F, 1'b0, 10);
        chki("ym1_we", n_ywe, 4);
        chki("ym1_oki_cs", n_ocs, 0);
        chki("ym1_dtack", n_dtk, 6);
        chk8("ym1_din", bus.YM2151_DIN, 8'h7F);
        chk1("ym1_wr_cmd", bus.YM2151_WR_CMD, 1'b1);

        // OKI write then status read
        cpu_cycle(2'd2, 1'b0, 8'h88, 1'b0, 10);
        chki("okiw_we", n_owe, 4);
        chki("okiw_cs", n_ocs, 4);
        chki("okiw_ym_cs", n_ycs, 0);
        chk8("okiw_din", bus.OKI_DIN, 8'h88);

        cpu_cycle(2'd2, 1'b1, 8'h00, 1'b0, 10);
        chki("okir_cs", n_ocs, 2);
        chki("okir_we", n_owe, 0);
        chki("okir_dtack", n_dtk, 8);
        chk8("okir_dout", bus.CPU_DOUT, 8'h0F);

        cpu_cycle(2'd0, 1'b1, 8'h00, 1'b0, 10);
        chki("ymr_cs", n_ycs, 2);
        chki("ymr_we", n_ywe, 0);
        chk8("ymr_dout", bus.CPU_DOUT, 8'h5A);

        // Bank register
        cpu_cycle(2'd3, 1'b0, 8'h01, 1'b0, 10);
        chki("bankw_cs", n_ycs + n_ocs, 0);
        chki("bankw_dtack", n_dtk, 6);
        chk1("bankw_bank", bus.OKI_BANK, 1'b1);

        cpu_cycle(2'd3, 1'b1, 8'h00, 1'b0, 10);
        chki("bankr_cs", n_ycs + n_ocs, 0);
        chki("bankr_dtack", n_dtk, 8);
        chk8("bankr_dout", bus.CPU_DOUT, 8'h01);

        cpu_cycle(2'd3, 1'b0, 8'hFE, 1'b0, 10);
        chki("bankw2_cs", n_ycs + n_ocs, 0);
        chk1("bankw2_bank", bus.OKI_BANK, 1'b0);

        // Address strobe held long: still one strobe
        cpu_cycle(2'd0, 1'b0, 8'h11, 1'b0, 50);
        chki("held_we", n_ywe, 4);
        chki("held_dtack", n_dtk, 46);

        // Upper-byte-only access
        cpu_cycle(2'd2, 1'b0, 8'h99, 1'b1, 10);
        chki("ub_cs", n_ycs + n_ocs, 0);
        chki("ub_we", n_ywe + n_owe, 0);
        chki("ub_dtack", n_dtk, 10);
        chk8("ub_oki_din", bus.OKI_DIN, 8'h88);

        // Abort in the 2nd ACCESS clock
        bus.SND_SEL = 1'b1; bus.CPU_A = 2'd1; bus.CPU_RW = 1'b0;
        bus.CPU_DIN = 8'h33; bus.CPU_LDS_N = 1'b0; bus.CPU_AS_N = 1'b0;
        @(negedge clk);
        chk1("abort_we1", bus.YM2151_WE, 1'b0);
        @(negedge clk);
        chk1("abort_cs2", bus.YM2151_CS, 1'b1);
        bus.CPU_AS_N = 1'b1; bus.CPU_LDS_N = 1'b1;
        @(negedge clk);
        chk1("abort_cs_drop", bus.YM2151_CS, 1'b0);
        chk1("abort_we_drop", bus.YM2151_WE, 1'b1);
        chk1("abort_no_dtack", bus.CPU_DTACK_N, 1'b1);
        @(negedge clk);
        chk1("abort_no_dtack2", bus.CPU_DTACK_N, 1'b1);

        // Aborted bank write keeps the bank value
        bus.SND_SEL = 1'b1; bus.CPU_A = 2'd3; bus.CPU_RW = 1'b0;
        bus.CPU_DIN = 8'h01; bus.CPU_LDS_N = 1'b0; bus.CPU_AS_N = 1'b0;
        @(negedge clk);
        bus.CPU_AS_N = 1'b1; bus.CPU_LDS_N = 1'b1;
        repeat (2) @(negedge clk);
        chk1("abort_bank", bus.OKI_BANK, 1'b1);
        chk1("abort_bank_dtack", bus.CPU_DTACK_N, 1'b1);

        // Asynchronous reset in the middle of an OKI write
        bus.SND_SEL = 1'b1; bus.CPU_A = 2'd2; bus.CPU_RW = 1'b0;
        bus.CPU_DIN = 8'h44; bus.CPU_LDS_N = 1'b0; bus.CPU_AS_N = 1'b0;
        @(negedge clk);
        chk1("mid_oki_cs", bus.OKI_CS, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        bus.CPU_AS_N = 1'b1; bus.CPU_LDS_N = 1'b1; bus.SND_SEL = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_cycle(2'd1, 1'b0, 8'h55, 1'b0, 8);
        chki("post_rst_we", n_ywe, 4);
        chki("post_rst_dtack", n_dtk, 4);
        chk8("post_rst_din", bus.YM2151_DIN, 8'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
